// File: rtl/register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_write_arbiter
// Description : Round-robin write arbiter for a 2**ADDR_WIDTH x DATA_WIDTH
//               register bank. Grants one requester per WRITE cycle, drives
//               the shared D bus and one-hot clock enables, and sequences a
//               one-cycle bank-wide clear that takes priority over writes.
// Revision    : 1.0 - initial release
// ============================================================================
module register_write_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                           clock,
  input  logic                           input_clear_n,
  input  logic [NUM_REQ-1:0]             input_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  input_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  input_data,
  input  logic                           input_clear_all,
  output logic [NUM_REQ-1:0]             output_grant,
  output logic [DATA_WIDTH-1:0]          output_d,
  output logic [(1<<ADDR_WIDTH)-1:0]     output_clock_enable,
  output logic                           output_clear,
  output logic                           output_busy
);

  localparam int NUM_REG   = 1 << ADDR_WIDTH;
  localparam int PTR_WIDTH = (NUM_REQ > 2) ? 2 : 1;
  // Wide enough to hold last (max 3) + offset (max 4) before the modulo fold
  localparam int SUM_WIDTH = PTR_WIDTH + 2;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
      $error("register_write_arbiter: NUM_REQ must be in 2..4");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  state_t                  state_q;
  logic [PTR_WIDTH-1:0]    last_q;
  logic                    clear_pending_q;
  logic [NUM_REQ-1:0]      grant_q;
  logic [DATA_WIDTH-1:0]   d_q;
  logic [NUM_REG-1:0]      ce_q;
  logic                    clear_q;
  logic                    busy_q;

  logic                    w_found;
  logic [PTR_WIDTH-1:0]    w_win;
  logic [SUM_WIDTH-1:0]    w_cand;
  logic [ADDR_WIDTH-1:0]   w_addr;
  logic [DATA_WIDTH-1:0]   w_data;

  // Round-robin search: first asserted request starting just after last winner
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = SUM_WIDTH'(last_q) + SUM_WIDTH'(k);
      if (w_cand >= SUM_WIDTH'(NUM_REQ)) begin
        w_cand = w_cand - SUM_WIDTH'(NUM_REQ);
      end
      if (!w_found && input_req[w_cand[PTR_WIDTH-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[PTR_WIDTH-1:0];
      end
    end
  end

  // Select the winning requester's address and data slices
  always_comb begin
    w_addr = '0;
    w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == PTR_WIDTH'(i)) begin
        w_addr = input_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_data = input_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Arbitration FSM; every output is loaded on the edge that enters its cycle
  always_ff @(posedge clock or negedge input_clear_n) begin
    if (!input_clear_n) begin
      state_q         <= ST_IDLE;
      last_q          <= PTR_WIDTH'(NUM_REQ - 1);
      clear_pending_q <= 1'b0;
      grant_q         <= '0;
      d_q             <= '0;
      ce_q            <= '0;
      clear_q         <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_pending_q || input_clear_all) begin
            // Clear wins over any pending write request
            state_q         <= ST_CLEAR;
            clear_pending_q <= 1'b0;
            grant_q         <= '0;
            d_q             <= '0;
            ce_q            <= '1;
            clear_q         <= 1'b1;
            busy_q          <= 1'b1;
          end else if (w_found) begin
            state_q <= ST_WRITE;
            last_q  <= w_win;
            grant_q <= NUM_REQ'(1) << w_win;
            d_q     <= w_data;
            ce_q    <= NUM_REG'(1) << w_addr;
            clear_q <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            // Idle: D bus keeps its last value
            grant_q <= '0;
            ce_q    <= '0;
            clear_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        ST_WRITE, ST_CLEAR: begin
          // Single-cycle operation; a clear pulse seen now is deferred
          state_q <= ST_IDLE;
          grant_q <= '0;
          ce_q    <= '0;
          clear_q <= 1'b0;
          if (input_clear_all) begin
            clear_pending_q <= 1'b1;
          end
          busy_q <= clear_pending_q | input_clear_all;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          ce_q    <= '0;
          clear_q <= 1'b0;
          busy_q  <= clear_pending_q;
        end
      endcase
    end
  end

  assign output_grant        = grant_q;
  assign output_d            = d_q;
  assign output_clock_enable = ce_q;
  assign output_clear        = clear_q;
  assign output_busy         = busy_q;

endmodule
`default_nettype wire
